vol_ctrl: RTL and testbench

Stereo volume controller that shares one registered signed multiplier between the left and right audio channels. It applies a slew-limited gain derived from the 12-bit volume pot reading. It sits between the codec sample-pair source and the DAC path, and replaces the per-channel scalers. Gain steps toward the pot value once per sample pair, which suppresses zipper noise.

---
 rtl/vol_pkg.sv | 33 +++
 rtl/vol_mult.sv | 29 ++
 rtl/vol_ctrl.sv | 119 +++++++++++
 tb/tb_vol_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/vol_pkg.sv
// Shared widths, FSM state encoding and the gain slew helper for the stereo volume controller.
package vol_pkg;

   localparam int GAIN_W  = 12;
   localparam int AUD_W   = 16;
   localparam int PROD_W  = 29;
   localparam int OUT_LSB = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL_L = 2'd1,
      MUL_R = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Compared one bit wider than the gain so gain+step and gain-step cannot wrap.
   function automatic logic [GAIN_W-1:0] slew(input logic [GAIN_W-1:0] gain,
                                              input logic [GAIN_W-1:0] pot,
                                              input logic [GAIN_W:0]   step);
      logic [GAIN_W:0] g;
      logic [GAIN_W:0] p;
      g = {1'b0, gain};
      p = {1'b0, pot};
      if (p > g + step) begin
         slew = gain + step[GAIN_W-1:0];
      end else if ((g >= step) && (p < g - step)) begin
         slew = gain - step[GAIN_W-1:0];
      end else begin
         slew = pot;
      end
   endfunction

endpackage

// File: rtl/vol_mult.sv
// Registered signed multiplier: unsigned gain (zero-extended to 13 bits) times a signed audio sample.
module vol_mult
   import vol_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [GAIN_W:0]   op_a,
   input  logic signed [AUD_W-1:0]  op_b,
   output logic signed [PROD_W-1:0] prod
);

   logic signed [PROD_W-1:0] prod_d;
   logic signed [PROD_W-1:0] prod_q;

   always_comb begin
      prod_d = PROD_W'(op_a) * PROD_W'(op_b);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
      end else begin
         prod_q <= prod_d;
      end
   end

   assign prod = prod_q;

endmodule

// File: rtl/vol_ctrl.sv
// Stereo volume controller: one shared multiplier, slew-limited gain stepped once per sample pair.
//
// state | meaning
// IDLE  | waiting for in_vld; on accept latch samples and step gain
// MUL_L | multiplier operands are gain and left sample
// MUL_R | operands gain and right; left product lands in lft_out
// DONE  | right product lands in rht_out; out_vld follows in IDLE
module vol_ctrl
   import vol_pkg::*;
#(
   parameter int unsigned STEP = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [GAIN_W-1:0] pot,
   input  logic              in_vld,
   input  logic [AUD_W-1:0]  lft_in,
   input  logic [AUD_W-1:0]  rht_in,
   output logic [AUD_W-1:0]  lft_out,
   output logic [AUD_W-1:0]  rht_out,
   output logic              out_vld,
   output logic              busy,
   output logic              ovr
);

   localparam logic [GAIN_W:0] STEP_W = (GAIN_W+1)'(STEP);

   state_e              state_q, state_d;
   logic [GAIN_W-1:0]   gain_q, gain_d;
   logic [AUD_W-1:0]    lft_smp_q, lft_smp_d;
   logic [AUD_W-1:0]    rht_smp_q, rht_smp_d;
   logic [AUD_W-1:0]    lft_out_q, lft_out_d;
   logic [AUD_W-1:0]    rht_out_q, rht_out_d;
   logic                out_vld_q, out_vld_d;
   logic                ovr_q, ovr_d;

   logic signed [GAIN_W:0]   mul_a;
   logic signed [AUD_W-1:0]  mul_b;
   logic signed [PROD_W-1:0] prod;
   logic [AUD_W-1:0]         prod_out;
   logic                     unused_prod_bits;

   // Gain is unsigned, so the product never reaches bit 28; no saturation needed.
   assign prod_out         = prod[OUT_LSB+AUD_W-1:OUT_LSB];
   assign unused_prod_bits = ^{prod[PROD_W-1], prod[OUT_LSB-1:0]};

   always_comb begin
      mul_a = signed'({1'b0, gain_q});
      mul_b = (state_q == MUL_L) ? signed'(lft_smp_q) : signed'(rht_smp_q);
   end

   vol_mult u_mult (
      .clk   (clk),
      .rst_n (rst_n),
      .op_a  (mul_a),
      .op_b  (mul_b),
      .prod  (prod)
   );

   always_comb begin
      state_d   = state_q;
      gain_d    = gain_q;
      lft_smp_d = lft_smp_q;
      rht_smp_d = rht_smp_q;
      lft_out_d = lft_out_q;
      rht_out_d = rht_out_q;
      out_vld_d = (state_q == DONE);
      ovr_d     = ovr_q | (in_vld && (state_q != IDLE));
      unique case (state_q)
         IDLE: begin
            if (in_vld) begin
               lft_smp_d = lft_in;
               rht_smp_d = rht_in;
               gain_d    = slew(gain_q, pot, STEP_W);
               state_d   = MUL_L;
            end
         end
         MUL_L: state_d = MUL_R;
         MUL_R: begin
            lft_out_d = prod_out;
            state_d   = DONE;
         end
         DONE: begin
            rht_out_d = prod_out;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gain_q    <= '0;
         lft_smp_q <= '0;
         rht_smp_q <= '0;
         lft_out_q <= '0;
         rht_out_q <= '0;
         out_vld_q <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gain_q    <= gain_d;
         lft_smp_q <= lft_smp_d;
         rht_smp_q <= rht_smp_d;
         lft_out_q <= lft_out_d;
         rht_out_q <= rht_out_d;
         out_vld_q <= out_vld_d;
         ovr_q     <= ovr_d;
      end
   end

   assign lft_out = lft_out_q;
   assign rht_out = rht_out_q;
   assign out_vld = out_vld_q;
   assign busy    = (state_q != IDLE);
   assign ovr     = ovr_q;

endmodule

// File: tb/tb_vol_ctrl.sv
// Directed bench for vol_ctrl: a STEP=8 instance for slew/overrun/reset cases, a STEP=4095 one for full scale.
module tb_vol_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] pot;
   logic        in_vld;
   logic [15:0] lft_in, rht_in;

   logic [15:0] lft_o, rht_o, lft_f, rht_f;
   logic        ovld_o, busy_o, ovr_o, ovld_f, busy_f, ovr_f;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   vol_ctrl #(.STEP(8)) dut (
      .clk(clk), .rst_n(rst_n), .pot(pot), .in_vld(in_vld),
      .lft_in(lft_in), .rht_in(rht_in),
      .lft_out(lft_o), .rht_out(rht_o), .out_vld(ovld_o), .busy(busy_o), .ovr(ovr_o)
   );

   vol_ctrl #(.STEP(4095)) dut_fs (
      .clk(clk), .rst_n(rst_n), .pot(pot), .in_vld(in_vld),
      .lft_in(lft_in), .rht_in(rht_in),
      .lft_out(lft_f), .rht_out(rht_f), .out_vld(ovld_f), .busy(busy_f), .ovr(ovr_f)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      in_vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Called on a negedge; returns on the negedge of the out_vld cycle.
   task automatic pair(input logic [15:0] l, input logic [15:0] r,
                       input logic [15:0] el, input logic [15:0] er,
                       input bit fs, input bit inj);
      in_vld = 1'b1; lft_in = l; rht_in = r;
      @(negedge clk);
      in_vld = 1'b0; lft_in = 16'h1234; rht_in = 16'h5678;
      chk("busy_mul_l", fs ? busy_f : busy_o, 1);
      chk("ovld_early", fs ? ovld_f : ovld_o, 0);
      @(negedge clk);
      chk("busy_mul_r", fs ? busy_f : busy_o, 1);
      if (inj) begin
         in_vld = 1'b1; lft_in = 16'h7FFF; rht_in = 16'h7FFF;
      end
      @(negedge clk);
      in_vld = 1'b0;
      chk("busy_done", fs ? busy_f : busy_o, 1);
      chk("lft_at_e2", fs ? lft_f : lft_o, el);
      @(negedge clk);
      chk("ovld", fs ? ovld_f : ovld_o, 1);
      chk("busy_idle", fs ? busy_f : busy_o, 0);
      chk("lft_out", fs ? lft_f : lft_o, el);
      chk("rht_out", fs ? rht_f : rht_o, er);
   endtask

   initial begin
      rst_n = 1'b0; in_vld = 1'b0; pot = 12'd0; lft_in = '0; rht_in = '0;
      #12;
      chk("rst_lft", lft_o, 0);
      chk("rst_rht", rht_o, 0);
      chk("rst_ovld", ovld_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_ovr", ovr_o, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Full scale, gain snaps straight to 4095
      pot = 12'd4095;
      pair(16'h7FFF, 16'h8000, 16'h7FF7, 16'h8008, 1'b1, 1'b0);

      // Slew ramp to 100 in steps of 8: output = gain * 0x4000 >> 12 = gain * 4
      do_reset();
      pot = 12'd100;
      for (int i = 1; i <= 14; i++) begin
         int g;
         g = (i <= 12) ? i * 8 : 100;
         pair(16'h4000, 16'h4000, 16'(g * 4), 16'(g * 4), 1'b0, 1'b0);
      end
      chk("ramp_p13_val", lft_o, 16'h0190);

      // Down-ramp: 100 -> 92 -> 90 -> 90
      pot = 12'd90;
      pair(16'h4000, 16'h4000, 16'd368, 16'd368, 1'b0, 1'b0);
      pair(16'h4000, 16'h4000, 16'd360, 16'd360, 1'b0, 1'b0);
      pair(16'h4000, 16'h4000, 16'd360, 16'd360, 1'b0, 1'b0);
      chk("ovr_clean", ovr_o, 0);

      // Overrun strobe during MUL_R is ignored; ovr sticks
      pair(16'h4000, 16'hC000, 16'h0168, 16'hFE98, 1'b0, 1'b1);
      chk("ovr_set", ovr_o, 1);
      pair(16'h2000, 16'h4000, 16'h00B4, 16'h0168, 1'b0, 1'b0);
      chk("ovr_sticky", ovr_o, 1);

      // Reset asserted during MUL_R
      in_vld = 1'b1; lft_in = 16'h4000; rht_in = 16'h4000;
      @(negedge clk);
      in_vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_lft", lft_o, 0);
      chk("mid_rst_rht", rht_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_ovr", ovr_o, 0);
      chk("mid_rst_ovld", ovld_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_ovld_after_rst", ovld_o, 0);
      end
      pair(16'h4000, 16'h4000, 16'h0020, 16'h0020, 1'b0, 1'b0);

      // Back-to-back: in_vld held high, gain 8 -> 16, 24, 32
      in_vld = 1'b1; lft_in = 16'h4000; rht_in = 16'h4000;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         chk("b2b_ovld", ovld_o, (n % 4 == 0) ? 1 : 0);
         if (n % 4 == 0) chk("b2b_lft", lft_o, 32'((8 + 8 * (n / 4)) * 4));
      end
      in_vld = 1'b0;
      chk("b2b_ovr", ovr_o, 1);
      repeat (6) @(negedge clk);
      chk("b2b_idle", busy_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
